// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//
// Shared definitions for the SHA-256 message padder:
//   - pad_state_t       : padder FSM state encoding (also exported on the
//                         padder's debug state output)
//   - BLOCK_WORDS       : number of 32-bit words in one 512-bit block
//   - MAX_BYTES_DEFAULT : largest message, in bytes, that still leaves room
//                         for the 0x80 marker and the 64-bit length field
//                         inside a single block (64 - 1 - 8 = 55)
//   - PAD_BYTE          : marker byte written right after the message
//   - clamp_nbytes()    : limits a last-beat byte count to one beat (8)
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int         BLOCK_WORDS       = 16;
    localparam int         MAX_BYTES_DEFAULT = 55;
    localparam logic [7:0] PAD_BYTE          = 8'h80;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PAD   = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4,
        DONE  = 3'd5,
        DROP  = 3'd6
    } pad_state_t;

    // A 64-bit beat never carries more than 8 bytes, whatever the sender claims.
    function automatic logic [3:0] clamp_nbytes(input logic [3:0] nb);
        return (nb > 4'd8) ? 4'd8 : nb;
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// ---------------------------------------------------------------------------
// sha256_blk_buf
//
// 16 x 32-bit block buffer feeding the hash core. Word 0 holds message
// bytes 0..3 with byte 0 in bits [31:24]; word 15 ends up holding the low
// 32 bits of the message bit length once the block is padded.
//
// Every word has its own write enable and write data lane so the padder can
// write two beat words, clear a range, or rewrite the whole block in a
// single cycle. The full contents are exported so the padder can compute
// the padded block from the bytes already stored.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset, clears every word
//   i_we       per-word write enable
//   i_wdata    per-word write data (lane w goes to word w)
//   i_raddr    combinational read address (driven by the hash core)
//   o_rdata    word at i_raddr
//   o_words    all 16 stored words, lane w = word w
// ---------------------------------------------------------------------------
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [BLOCK_WORDS-1:0]        i_we,
    input  logic [BLOCK_WORDS-1:0][31:0]  i_wdata,
    input  logic [3:0]                    i_raddr,
    output logic [31:0]                   o_rdata,
    output logic [BLOCK_WORDS-1:0][31:0]  o_words
);

    logic [BLOCK_WORDS-1:0][31:0] r_mem;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem <= '0;
        end else begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                if (i_we[w]) begin
                    r_mem[w] <= i_wdata[w];
                end
            end
        end
    end

    // The core addresses words directly; no registering on the read side.
    assign o_rdata = r_mem[i_raddr];
    assign o_words = r_mem;

endmodule

// File: rtl/sha256_msg_pad.sv
// ---------------------------------------------------------------------------
// sha256_msg_pad
//
// Collects a short message (at most MAX_BYTES bytes) arriving as 64-bit
// beats, builds the single padded SHA-256 block in sha256_blk_buf, starts
// the hash core once, and reports completion. Messages that cannot fit in
// one block are discarded and reported with an err pulse; the core is never
// started for them.
//
// Handshake: a beat (in_data, in_last, in_nbytes) transfers on a rising
// edge where in_valid and in_ready are both high. in_ready is registered
// and depends only on the FSM state, never on in_valid. The sender holds
// its beat stable until it transfers. Non-last beats carry 8 bytes; the
// last beat carries in_nbytes bytes (0..8, larger values count as 8), with
// the first byte in bits [63:56].
//
// Core side: core_update is a one-cycle start pulse issued when core_ready
// is high. The core then reads the block through core_addr/core_word
// (combinational). The run is complete once core_ready has been seen low
// and then high again; done pulses for one cycle at that point.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   in_data      message beat
//   in_valid     beat valid
//   in_last      final beat of the message
//   in_nbytes    valid bytes in the final beat
//   in_ready     padder can accept a beat
//   core_ready   hash core idle / finished
//   core_update  start pulse to the hash core
//   core_addr    word address from the hash core
//   core_word    buffer word at core_addr
//   done         one-cycle pulse, digest valid
//   err          one-cycle pulse, oversize message dropped
//   o_dbg_state  current FSM state (pad_state_t encoding)
// ---------------------------------------------------------------------------
module sha256_msg_pad
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [3:0]  in_nbytes,
    output logic        in_ready,
    input  logic        core_ready,
    output logic        core_update,
    input  logic [3:0]  core_addr,
    output logic [31:0] core_word,
    output logic        done,
    output logic        err,
    output logic [2:0]  o_dbg_state
);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    pad_state_t r_state;
    logic [5:0] r_byte_cnt;   // bytes received in completed non-last beats
    logic [5:0] r_total;      // final message length, valid from PAD onwards
    logic       r_seen_low;   // core_ready observed low since the start pulse
    logic       r_in_ready;
    logic       r_core_update;
    logic       r_done;
    logic       r_err;

    // -----------------------------------------------------------------------
    // Beat accounting
    // -----------------------------------------------------------------------
    logic                         w_accept;
    logic [3:0]                   w_nb;
    logic [3:0]                   w_beat_bytes;
    logic [6:0]                   w_sum;
    logic                         w_over;
    logic [2:0]                   w_beat_idx;

    logic [BLOCK_WORDS-1:0]       w_we;
    logic [BLOCK_WORDS-1:0][31:0] w_wdata;
    logic [BLOCK_WORDS-1:0][31:0] w_buf_words;
    logic [BLOCK_WORDS-1:0][31:0] w_pad_words;

    assign w_accept     = in_valid && r_in_ready;
    assign w_nb         = clamp_nbytes(in_nbytes);
    assign w_beat_bytes = in_last ? w_nb : 4'd8;
    // One spare bit so a count past 63 cannot wrap below MAX_BYTES.
    assign w_sum        = {1'b0, r_byte_cnt} + {3'b000, w_beat_bytes};
    assign w_over       = (w_sum > 7'(MAX_BYTES));
    // r_byte_cnt is always a multiple of 8 while loading, so its upper bits
    // are the index of the beat now arriving.
    assign w_beat_idx   = r_byte_cnt[5:3];

    // -----------------------------------------------------------------------
    // Padded block: keep message bytes, put the marker right after them,
    // zero the rest, then overwrite the length field. Since the message is
    // at most 55 bytes, words 14..15 never hold message data.
    // -----------------------------------------------------------------------
    always_comb begin
        w_pad_words = w_buf_words;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (6'(4 * w + b) == r_total) begin
                    w_pad_words[w][31 - 8 * b -: 8] = PAD_BYTE;
                end else if (6'(4 * w + b) > r_total) begin
                    w_pad_words[w][31 - 8 * b -: 8] = 8'h00;
                end
            end
        end
        w_pad_words[14] = 32'h0000_0000;
        w_pad_words[15] = {23'd0, r_total, 3'b000};
    end

    // -----------------------------------------------------------------------
    // Buffer write control
    // -----------------------------------------------------------------------
    always_comb begin
        w_we    = '0;
        w_wdata = '0;
        case (r_state)
            IDLE, LOAD: begin
                if (w_accept && !w_over) begin
                    w_we[{w_beat_idx, 1'b0}]    = 1'b1;
                    w_we[{w_beat_idx, 1'b1}]    = 1'b1;
                    w_wdata[{w_beat_idx, 1'b0}] = in_data[63:32];
                    w_wdata[{w_beat_idx, 1'b1}] = in_data[31:0];
                    // First beat of a message wipes whatever the previous
                    // message left behind (write data lanes are already 0).
                    if (r_state == IDLE) begin
                        for (int w = 2; w < BLOCK_WORDS; w++) begin
                            w_we[w] = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                w_we    = '1;
                w_wdata = w_pad_words;
            end
            default: begin
            end
        endcase
    end

    sha256_blk_buf u_buf (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .i_raddr (core_addr),
        .o_rdata (core_word),
        .o_words (w_buf_words)
    );

    // -----------------------------------------------------------------------
    // Control FSM. Pulse outputs default low every cycle and are raised only
    // on the transition that owns them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_byte_cnt    <= '0;
            r_total       <= '0;
            r_seen_low    <= 1'b0;
            r_in_ready    <= 1'b0;
            r_core_update <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_core_update <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;

            case (r_state)
                IDLE, LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_over) begin
                            r_byte_cnt <= '0;
                            if (in_last) begin
                                r_err   <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_state <= DROP;
                            end
                        end else if (in_last) begin
                            r_total    <= w_sum[5:0];
                            r_byte_cnt <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= PAD;
                        end else begin
                            r_byte_cnt <= w_sum[5:0];
                            r_state    <= LOAD;
                        end
                    end
                end

                PAD: begin
                    r_in_ready <= 1'b0;
                    r_state    <= START;
                end

                START: begin
                    r_in_ready <= 1'b0;
                    if (core_ready) begin
                        r_core_update <= 1'b1;
                        r_seen_low    <= 1'b0;
                        r_state       <= BUSY;
                    end
                end

                BUSY: begin
                    r_in_ready <= 1'b0;
                    // A core that has not yet reacted to the start pulse still
                    // shows ready high; only a low-then-high sequence counts.
                    if (!core_ready) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
                end

                DROP: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && in_last) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign core_update = r_core_update;
    assign done        = r_done;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sha256_msg_pad.sv
`timescale 1ns/1ps
module tb_sha256_msg_pad;

  localparam int W    = 513;   // bit 512 = "dropped" marker, [511:0] = block
  localparam int MAXB = 55;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [3:0]  in_nbytes;
  logic        in_ready;
  logic        core_ready;
  logic        core_update;
  logic [3:0]  core_addr;
  logic [31:0] core_word;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  sha256_msg_pad dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .in_ready    (in_ready),
    .core_ready  (core_ready),
    .core_update (core_update),
    .core_addr   (core_addr),
    .core_word   (core_word),
    .done        (done),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   msg_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_update = 0;
  int n_valid  = 0;

  bit hold_core        = 1'b0;
  bit stall_after_read = 1'b0;
  bit read_done        = 1'b0;
  bit aborted          = 1'b0;
  bit mon_busy         = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Single padded SHA-256 block: message bytes, 0x80, zeros, 64-bit big-endian bit length.
  function automatic logic [511:0] model_block(input int len);
    logic [7:0]   b[64];
    logic [63:0]  bits;
    logic [511:0] r;
    for (int i = 0; i < 64; i++) begin
      b[i] = 8'h00;
      if (i < len) b[i] = msg_q[i];
    end
    b[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) b[56 + i] = bits[63 - 8 * i -: 8];
    for (int i = 0; i < 64; i++) r[511 - 8 * i -: 8] = b[i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic lst, input logic [3:0] nb);
    int cyc;
    @(negedge clk);
    in_data   = d;
    in_last   = lst;
    in_nbytes = nb;
    in_valid  = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) begin
      check("in_ready_timeout", 64'(cyc), 64'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic fill_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_msg();
    int len, beats;
    logic [63:0] d;
    logic [3:0]  nb;
    logic        lst;
    len = msg_q.size();
    if (len > MAXB) begin
      exp_q.push_back({1'b1, 512'd0});
    end else begin
      exp_q.push_back({1'b0, model_block(len)});
      n_valid++;
    end
    beats = (len == 0) ? 1 : (len + 7) / 8;
    for (int k = 0; k < beats; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (8 * k + j < len) d[63 - 8 * j -: 8] = msg_q[8 * k + j];
        else                 d[63 - 8 * j -: 8] = 8'($urandom_range(0, 255));
      end
      lst = (k == beats - 1);
      if (!lst)                        nb = 4'($urandom_range(0, 15));
      else if (len % 8 == 0 && len > 0) nb = 4'($urandom_range(8, 15));
      else                             nb = 4'(len % 8);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_beat(d, lst, nb);
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || mon_busy) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_timeout", 64'(cyc >= 2000), 64'd0);
  endtask

  // ---------------- core model + monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [511:0] blk;
    bit found, early_done;
    core_ready = 1'b1;
    core_addr  = 4'd0;
    forever begin
      @(negedge clk);
      core_ready = !hold_core;
      if (err) begin
        check("err_in_ready_next", 64'(in_ready), 64'd1);
        if (exp_q.size() == 0) begin
          check("err_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_for_valid_msg", 64'(e[512]), 64'd1);
        end
      end
      if (done) check("spurious_done", 64'(done), 64'd0);
      if (core_update) begin
        mon_busy = 1'b1;
        n_update++;
        check("in_ready_at_update", 64'(in_ready), 64'd0);
        blk = '0;
        if (exp_q.size() == 0) begin
          check("update_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("update_for_dropped", 64'(e[512]), 64'd0);
          blk = e[511:0];
        end
        core_ready = 1'b0;
        early_done = 1'b0;
        for (int a = 0; a < 16; a++) begin
          @(negedge clk);
          if (a == 0) check("update_width", 64'(core_update), 64'd0);
          if (done) early_done = 1'b1;
          core_addr = 4'(a);
          #1;
          check($sformatf("word%0d", a), 64'(core_word), 64'(blk[511 - 32 * a -: 32]));
        end
        check("done_before_core_ready", 64'(early_done), 64'd0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        if (stall_after_read) begin
          read_done = 1'b1;
          wait (!stall_after_read);
          @(negedge clk);
        end
        core_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
          @(negedge clk);
          if (done) found = 1'b1;
        end
        if (aborted) begin
          check("done_after_reset", 64'(found), 64'd0);
        end else begin
          check("done_seen", 64'(found), 64'd1);
          if (found) begin
            check("in_ready_at_done", 64'(in_ready), 64'd0);
            @(negedge clk);
            check("done_width", 64'(done), 64'd0);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int cyc, len;
    bit upd_seen;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nbytes = 4'd0;
    in_data   = 64'd0;
    rst_i     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_core_update", 64'(core_update), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(sha256_pkg::IDLE));
    rst_i = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // "abcd"
    msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    send_msg();
    // empty message
    msg_q.delete();
    send_msg();
    // largest message that fits, then the two oversize cases
    fill_msg(55); send_msg();
    fill_msg(56); send_msg();
    fill_msg(72); send_msg();
    wait_idle();

    // core_ready held low while the padder waits in START
    hold_core = 1'b1;
    fill_msg(20);
    send_msg();
    upd_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (core_update) upd_seen = 1'b1;
    end
    check("update_while_held", 64'(upd_seen), 64'd0);
    hold_core = 1'b0;
    wait_idle();

    // reset while the core is busy: no done, next message fine
    stall_after_read = 1'b1;
    fill_msg(12);
    send_msg();
    cyc = 0;
    while (!read_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("read_done_timeout", 64'(cyc >= 400), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;
    aborted = 1'b1;
    stall_after_read = 1'b0;
    @(negedge clk);
    check("in_ready_after_midreset", 64'(in_ready), 64'd1);
    repeat (15) @(negedge clk);
    aborted   = 1'b0;
    read_done = 1'b0;
    wait_idle();
    fill_msg(30);
    send_msg();

    // random traffic
    repeat (40) begin
      if ($urandom_range(0, 9) < 7) len = $urandom_range(0, 55);
      else                          len = $urandom_range(56, 72);
      fill_msg(len);
      send_msg();
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("update_count", 64'(n_update), 64'(n_valid));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
